// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: ALU vs load port, with ALU starvation guard.
// One accepted request per cycle; writes to x0 are accepted but dropped.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIM = 3
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ALU_VALID,
    input  logic [4:0]  ALU_ADDR,
    input  logic [31:0] ALU_DATA,
    output logic        ALU_READY,
    input  logic        MEM_VALID,
    input  logic [4:0]  MEM_ADDR,
    input  logic [31:0] MEM_DATA,
    output logic        MEM_READY,
    output logic        WRITE,
    output logic [4:0]  INADDRESS,
    output logic [31:0] WDATA,
    output logic        INSTHIT,
    output logic [15:0] WR_COUNT
);

    typedef enum logic {
        PRI_MEM,
        PRI_ALU
    } pri_t;

    localparam logic [2:0] LIM_M1 = 3'(STARVE_LIM - 1);

    pri_t        state;
    logic [2:0]  starve;
    logic        alu_go;
    logic        mem_go;
    logic        xfer;
    logic [4:0]  g_addr;
    logic [31:0] g_data;
    logic        wr_en;

    always_comb begin
        alu_go = 1'b0;
        mem_go = 1'b0;
        if (RESET_N) begin
            if (state == PRI_ALU) begin
                alu_go = ALU_VALID;
                mem_go = MEM_VALID & ~ALU_VALID;
            end else begin
                mem_go = MEM_VALID;
                alu_go = ALU_VALID & ~MEM_VALID;
            end
        end
    end

    assign ALU_READY = alu_go;
    assign MEM_READY = mem_go;
    assign xfer      = alu_go | mem_go;
    assign g_addr    = alu_go ? ALU_ADDR : MEM_ADDR;
    assign g_data    = alu_go ? ALU_DATA : MEM_DATA;
    assign wr_en     = xfer & (g_addr != 5'd0);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= PRI_MEM;
            starve <= 3'd0;
        end else begin
            case (state)
                PRI_MEM: begin
                    if (ALU_VALID && !alu_go) begin
                        if (starve == LIM_M1) begin
                            state  <= PRI_ALU;
                            starve <= 3'd0;
                        end else begin
                            starve <= starve + 3'd1;
                        end
                    end else begin
                        starve <= 3'd0;
                    end
                end
                default: begin
                    // One ALU grant (or an idle ALU) hands priority back.
                    state  <= PRI_MEM;
                    starve <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            WRITE     <= 1'b0;
            INSTHIT   <= 1'b0;
            INADDRESS <= 5'd0;
            WDATA     <= 32'd0;
            WR_COUNT  <= 16'd0;
        end else begin
            WRITE   <= wr_en;
            INSTHIT <= wr_en;
            if (wr_en) begin
                INADDRESS <= g_addr;
                WDATA     <= g_data;
                if (WR_COUNT != 16'hFFFF)
                    WR_COUNT <= WR_COUNT + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter against a grant-rule reference model.
// Driver pushes expected writeback state; monitor pops and compares each cycle.
module tb_regfile_wb_arbiter;

    localparam int LIM = 3;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        ALU_VALID = 1'b0;
    logic [4:0]  ALU_ADDR = '0;
    logic [31:0] ALU_DATA = '0;
    logic        ALU_READY;
    logic        MEM_VALID = 1'b0;
    logic [4:0]  MEM_ADDR = '0;
    logic [31:0] MEM_DATA = '0;
    logic        MEM_READY;
    logic        WRITE;
    logic [4:0]  INADDRESS;
    logic [31:0] WDATA;
    logic        INSTHIT;
    logic [15:0] WR_COUNT;

    regfile_wb_arbiter #(.STARVE_LIM(LIM)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA),
        .ALU_READY(ALU_READY),
        .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
        .MEM_READY(MEM_READY),
        .WRITE(WRITE), .INADDRESS(INADDRESS), .WDATA(WDATA),
        .INSTHIT(INSTHIT), .WR_COUNT(WR_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        logic [15:0] c;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: who is owed a turn, how long ALU has waited,
    // and the architectural view of the writeback port.
    bit          m_owed;
    int          m_wait;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_cnt;
    bit          last_alu;
    bit          last_mem;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_owed = 0;
        m_wait = 0;
        m_addr = '0;
        m_data = '0;
        m_cnt  = 0;
        q.delete();
    endtask

    // Called just after a negedge: apply inputs, check grants, queue result.
    task automatic drive(input bit av, input logic [4:0] aa,
                         input logic [31:0] ad, input bit mv,
                         input logic [4:0] ma, input logic [31:0] md);
        bit ga, gm, w;
        exp_t e;
        ALU_VALID = av; ALU_ADDR = aa; ALU_DATA = ad;
        MEM_VALID = mv; MEM_ADDR = ma; MEM_DATA = md;
        #1;
        if (m_owed) begin
            ga = av;
            gm = mv && !av;
            m_owed = 0;
            m_wait = 0;
        end else begin
            gm = mv;
            ga = av && !mv;
            if (av && !ga) begin
                m_wait++;
                if (m_wait == LIM) begin
                    m_owed = 1;
                    m_wait = 0;
                end
            end else begin
                m_wait = 0;
            end
        end
        check("alu_ready", {31'd0, ALU_READY}, {31'd0, ga});
        check("mem_ready", {31'd0, MEM_READY}, {31'd0, gm});
        last_alu = ga;
        last_mem = gm;
        w = 0;
        if (ga && aa != 0) begin
            w = 1; m_addr = aa; m_data = ad;
        end else if (gm && ma != 0) begin
            w = 1; m_addr = ma; m_data = md;
        end
        if (w && m_cnt < 65535) m_cnt++;
        e.w = w; e.a = m_addr; e.d = m_data; e.c = 16'(m_cnt);
        q.push_back(e);
    endtask

    task automatic idle();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    // Monitor: compares registered outputs one step after each posedge.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (RESET_N && q.size() > 0) begin
            e = q.pop_front();
            check("write", {31'd0, WRITE}, {31'd0, e.w});
            check("insthit", {31'd0, INSTHIT}, {31'd0, e.w});
            check("inaddress", {27'd0, INADDRESS}, {27'd0, e.a});
            check("wdata", WDATA, e.d);
            check("wr_count", {16'd0, WR_COUNT}, {16'd0, e.c});
        end
    end

    initial begin
        int alu_pat;
        model_reset();
        #12;
        check("rst_write", {31'd0, WRITE}, 32'd0);
        check("rst_count", {16'd0, WR_COUNT}, 32'd0);
        check("rst_addr", {27'd0, INADDRESS}, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Single ALU write, available in the first cycle after release.
        drive(1, 5'd5, 32'h95, 0, 5'd0, 32'd0);
        check("single_grant", {31'd0, ALU_READY}, 32'd1);
        @(negedge CLK);
        check("single_write", {31'd0, WRITE}, 32'd1);
        check("single_addr", {27'd0, INADDRESS}, 32'd5);
        check("single_data", WDATA, 32'h95);
        check("single_cnt", {16'd0, WR_COUNT}, 32'd1);
        idle();

        // Contention: MEM first, ALU next cycle.
        @(negedge CLK);
        drive(1, 5'd1, 32'd50, 1, 5'd2, 32'd28);
        check("cont_mem_first", {31'd0, MEM_READY}, 32'd1);
        @(negedge CLK);
        drive(1, 5'd1, 32'd50, 0, 5'd0, 32'd0);
        check("cont_addr2", {27'd0, INADDRESS}, 32'd2);
        check("cont_alu_next", {31'd0, ALU_READY}, 32'd1);
        @(negedge CLK);
        idle();
        check("cont_addr1", {27'd0, INADDRESS}, 32'd1);

        // Starvation: ALU wins every fourth cycle with both held valid.
        @(negedge CLK);
        idle();
        alu_pat = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            drive(1, 5'd7, 32'(100 + i), 1, 5'd8, 32'(200 + i));
            alu_pat |= int'(ALU_READY) << i;
        end
        check("starve_pattern", 32'(alu_pat), 32'h888);
        @(negedge CLK);
        idle();

        // x0 write accepted but dropped.
        @(negedge CLK);
        drive(0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFF);
        check("x0_ready", {31'd0, MEM_READY}, 32'd1);
        @(negedge CLK);
        idle();
        check("x0_nowrite", {31'd0, WRITE}, 32'd0);

        // Randomized traffic, small address range so x0 and collisions occur.
        for (int i = 0; i < 1500; i++) begin
            @(negedge CLK);
            drive(bit'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 3)),
                  $urandom, bit'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), $urandom);
        end
        @(negedge CLK);
        idle();

        // Asynchronous reset while WRITE is high.
        @(negedge CLK);
        drive(1, 5'd9, 32'hABCD, 1, 5'd10, 32'h1234);
        @(posedge CLK);
        #3;
        check("pre_rst_write", {31'd0, WRITE}, 32'd1);
        RESET_N = 1'b0;
        #1;
        model_reset();
        check("arst_write", {31'd0, WRITE}, 32'd0);
        check("arst_insthit", {31'd0, INSTHIT}, 32'd0);
        check("arst_count", {16'd0, WR_COUNT}, 32'd0);
        check("arst_alu_rdy", {31'd0, ALU_READY}, 32'd0);
        check("arst_mem_rdy", {31'd0, MEM_READY}, 32'd0);
        @(posedge CLK);
        #1;
        check("rst_hold_write", {31'd0, WRITE}, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        idle();
        @(negedge CLK);
        check("post_rst_nowrite", {31'd0, WRITE}, 32'd0);

        // Saturation of WR_COUNT.
        for (int i = 0; i < 65535; i++) begin
            drive(0, 5'd0, 32'd0, 1, 5'd3, 32'(i));
            @(negedge CLK);
        end
        check("sat_preload", {16'd0, WR_COUNT}, 32'hFFFF);
        drive(0, 5'd0, 32'd0, 1, 5'd4, 32'hDEAD);
        @(negedge CLK);
        check("sat_hold", {16'd0, WR_COUNT}, 32'hFFFF);
        check("sat_write", {31'd0, WRITE}, 32'd1);
        idle();
        @(negedge CLK);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
